uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART serial receiver, the successor to the fixed 8N1 / 9600 baud receiver. It adds configurable data width, parity, stop bits and baud rate. It also adds an input synchroniser, mid-bit majority-vote sampling and a valid/ready output handshake with error reporting. It sits between the board RX pin and the byte-consuming logic (command parser / FIFO).

Parameters:
CLK_FREQ, 25000000, clock frequency in Hz
BAUD, 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 2604 at defaults), must be >= 8 (elaboration error otherwise)
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
input_stream  in  1  raw serial line, idle high, asynchronous to clock
data_out  out  DATA_BITS  received word, stable while data_valid=1
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts; transfer when data_valid & data_ready
parity_err  out  1  one-cycle pulse: parity mismatch, frame discarded
frame_err  out  1  one-cycle pulse: stop bit sampled 0, frame discarded
overrun  out  1  one-cycle pulse: good frame completed while data_valid=1, frame discarded
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, while reset_n=0): FSM=IDLE, counters=0, data_out=0, data_valid=0, all error pulses=0, busy=0. Synchroniser flops reset to 1 (line idle). Reset mid-frame aborts the frame and delivers nothing.
- input_stream passes through a 2-flop synchroniser (rx_s); rx_s lags the pin by 2 cycles.
- Bit sample = majority of rx_s at bit-counter values MID-1, MID, MID+1, where MID = CLKS_PER_BIT/2. The decision is taken at MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 -> START, bit counter cleared to 0.
  - START: at MID+1, sample=1 -> false start, back to IDLE with no pulse. Sample=0 -> DATA; the counter rebases so later samples fall at CLKS_PER_BIT spacing.
  - DATA: samples DATA_BITS bits LSB first into a shift register. After the last bit -> PARITY if PARITY!=0, else STOP.
  - PARITY: samples 1 bit. Even: the XOR of data bits plus the parity bit must be 0. Odd: it must be 1. A mismatch is latched internally.
  - STOP: samples STOP_BITS bits. Any stop sample 0 -> frame_err pulse; the FSM then waits in IDLE-hold until rx_s=1 (break handling) before it re-arms. Otherwise, after the last stop sample, the FSM returns to IDLE in the same cycle, allowing back-to-back frames with no idle gap.
- Completion, taken on the cycle after the final stop sample, with priority frame_err > parity_err > overrun > deliver. Deliver: data_out <= shift register, data_valid <= 1. Only one pulse fires per frame.
- Handshake: data_valid stays high and data_out is held until a cycle with data_ready=1; data_valid clears on the next edge. If consumption and a new delivery occur in the same cycle, the new word is loaded, data_valid stays 1 and no overrun is raised.
- Latency: data_valid rises 2 + (CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS-1)) + MID + 2 cycles after the start edge at the pin, where P = 1 if PARITY!=0, else 0. The exact count is checked by the bench at CLKS_PER_BIT=16.
- With DATA_BITS<9, no unused output bits exist because data_out is DATA_BITS wide.

Decomposition:
- Package uart_pkg:
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP)
  - function clks_per_bit(freq, baud)
- Sub-module uart_rx_sample: 2-flop synchroniser plus 3-tap majority voter. Ports: clock, reset_n, input_stream, rx_s, sample_bit. It is shared with the future transmitter loopback checker.
- Top FSM, counters and handshake stay in uart_rx_param.

Test Plan:
- CLK_FREQ=16*BAUD, 8N1, send 0xA5, data_ready=1 -> data_valid one cycle, data_out=0xA5, no error pulses, latency per formula.
- 8E1, send 0x3C with correct parity 0 -> delivered. Same frame with parity bit 1 -> parity_err pulse, data_valid stays 0.
- 7O2, send 0x55 with the second stop bit forced 0 -> frame_err. Line then held low 30 bit times -> no further frames until the line returns high, then 0x12 received correctly.
- 1-cycle glitch low, and separately a low of CLKS_PER_BIT/4, on an idle line -> no frame start/delivery and no error pulses. One-cycle spike inside data bit 3 of 0xF0 -> majority vote still yields 0xF0.
- data_ready=0, send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun pulse at the end of frame 2. Then raise data_ready -> data_valid clears the next cycle.
- Assert reset_n=0 mid data bit 4 -> all outputs 0 immediately. Release reset, send 0x81 -> 0x81 delivered cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and baud helper for the UART receiver
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD  parity mode encodings
//   rx_state_t                     receiver FSM states
//   clks_per_bit(freq, baud)       clock cycles per line bit (integer divide)
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sample.sv
// rtl/uart_rx_sample.sv - RX pin synchroniser and 3-tap majority voter
// Ports:
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   input_stream  in   raw serial line, idle high, asynchronous to clock
//   rx_s          out  synchronised line, 2 cycles behind the pin
//   sample_bit    out  majority of rx_s over the current and two previous cycles
module uart_rx_sample
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic input_stream,
  output logic rx_s,
  output logic sample_bit
);

  logic       meta;
  logic [1:0] hist;

  // All taps reset high so an idle line never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= 2'b11;
    end else begin
      meta <= input_stream;
      rx_s <= meta;
      hist <= {hist[0], rx_s};
    end
  end

  // The receiver consumes this when its bit counter is at MID+1, so the three
  // taps are rx_s at counter values MID+1, MID and MID-1.
  assign sample_bit = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output and error pulses
// Ports:
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   input_stream  in   raw serial line, idle high
//   data_out      out  received word (DATA_BITS), held while data_valid=1
//   data_valid    out  data_out holds an unconsumed word
//   data_ready    in   consumer accepts the word when data_valid=1
//   parity_err    out  one-cycle pulse, parity mismatch, frame dropped
//   frame_err     out  one-cycle pulse, a stop bit sampled 0, frame dropped
//   overrun       out  one-cycle pulse, good frame arrived while a word was pending
//   busy          out  FSM is not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 input_stream,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);

  if (CPB < 8) begin : g_bad_cpb
    $error("uart_rx_param: CLK_FREQ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_s;
  logic sample_bit;

  uart_rx_sample u_sample (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_stream (input_stream),
    .rx_s         (rx_s),
    .sample_bit   (sample_bit)
  );

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 stop_bad, stop_bad_n;
  logic                 hold, hold_n;
  logic                 tick;
  logic                 done;
  logic                 frame_bad;
  logic [DATA_BITS-1:0] dout_n;
  logic                 dv_n, pe_n, fe_n, ov_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      hold       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      stop_bad   <= stop_bad_n;
      hold       <= hold_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
      overrun    <= ov_n;
    end
  end

  always_comb begin
    state_n    = state;
    // The counter free-runs modulo CPB once a frame starts; it is cleared on
    // START entry, so every bit decision after the start bit lands exactly
    // CPB cycles after the previous one at counter value MID+1.
    cnt_n      = (cnt == CW'(CPB - 1)) ? '0 : cnt + CW'(1);
    bit_n      = bit_idx;
    shreg_n    = shreg;
    par_bad_n  = par_bad;
    stop_bad_n = stop_bad;
    hold_n     = hold;
    done       = 1'b0;
    frame_bad  = 1'b0;
    tick       = (cnt == CW'(MID + 1));

    case (state)
      ST_IDLE: begin
        cnt_n      = '0;
        bit_n      = '0;
        par_bad_n  = 1'b0;
        stop_bad_n = 1'b0;
        // After a framing error the line may sit low (break); wait for it to
        // return high before a falling level can start a new frame.
        if (hold) begin
          if (rx_s) hold_n = 1'b0;
        end else if (!rx_s) begin
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_n = sample_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_n = {sample_bit, shreg[DATA_BITS-1:1]};
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_bad_n = (((^shreg) ^ sample_bit) != (PARITY == PAR_ODD));
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (!sample_bit) stop_bad_n = 1'b1;
          if (bit_idx == 4'(STOP_BITS - 1)) begin
            done      = 1'b1;
            frame_bad = stop_bad | ~sample_bit;
            hold_n    = frame_bad;
            bit_n     = '0;
            state_n   = ST_IDLE;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Completion and handshake. A consume in the same cycle as a good frame
  // frees the slot, so the new word loads without an overrun.
  always_comb begin
    dout_n = data_out;
    dv_n   = data_valid & ~data_ready;
    pe_n   = 1'b0;
    fe_n   = 1'b0;
    ov_n   = 1'b0;
    if (done) begin
      if (frame_bad) begin
        fe_n = 1'b1;
      end else if (par_bad) begin
        pe_n = 1'b1;
      end else if (dv_n) begin
        ov_n = 1'b1;
      end else begin
        dout_n = shreg;
        dv_n   = 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param (8N1, 8E1, 7O2 at 16 clocks/bit)
module tb_uart_rx_param;

  localparam int BAUD     = 9600;
  localparam int CPB      = 16;
  localparam int CLK_FREQ = CPB * BAUD;
  localparam int MID      = CPB / 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic line[3];
  logic rdy[3];
  logic dv[3], pe[3], fe[3], ov[3], bz[3];
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  logic [8:0] dw[3];

  always #5 clock = ~clock;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .reset_n(reset_n), .input_stream(line[0]), .data_out(d0), .data_valid(dv[0]),
    .data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clock(clock), .reset_n(reset_n), .input_stream(line[1]), .data_out(d1), .data_valid(dv[1]),
    .data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clock(clock), .reset_n(reset_n), .input_stream(line[2]), .data_out(d2), .data_valid(dv[2]),
    .data_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

  assign dw[0] = {1'b0, d0};
  assign dw[1] = {1'b0, d1};
  assign dw[2] = {2'b00, d2};

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_dv[3], n_hi[3], n_pe[3], n_fe[3], n_ov[3], n_acc[3];
  int rise_cyc[3], start_cyc[3];
  logic [8:0] last_dv[3], last_acc[3];
  logic dv_q[3];

  always @(posedge clock) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle while DUT outputs and bench inputs are stable.
  initial begin
    for (int i = 0; i < 3; i++) begin
      n_dv[i] = 0; n_hi[i] = 0; n_pe[i] = 0; n_fe[i] = 0; n_ov[i] = 0; n_acc[i] = 0;
      rise_cyc[i] = 0; last_dv[i] = '0; last_acc[i] = '0; dv_q[i] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (dv[i] && !dv_q[i]) begin
          n_dv[i]++;
          rise_cyc[i] = cyc;
          last_dv[i] = dw[i];
        end
        if (dv[i]) n_hi[i]++;
        if (dv[i] && rdy[i]) begin
          n_acc[i]++;
          last_acc[i] = dw[i];
        end
        if (pe[i]) n_pe[i]++;
        if (fe[i]) n_fe[i]++;
        if (ov[i]) n_ov[i]++;
        dv_q[i] = dv[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Caller is at posedge+1. Frame bit k is held for CPB cycles; optionally one
  // cycle (gbit, goff) is inverted to model a spike.
  task automatic send(input int idx, input logic [15:0] fr, input int n,
                      input int gbit = -1, input int goff = 0);
    start_cyc[idx] = cyc;
    for (int k = 0; k < n; k++) begin
      for (int o = 0; o < CPB; o++) begin
        line[idx] = (k == gbit && o == goff) ? ~fr[k] : fr[k];
        tick(1);
      end
    end
    line[idx] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    reset_n = 1'b0;
    tick(3);
    chk("reset_dout", {24'd0, d0}, 32'h0);
    chk("reset_flags", {dv[0], pe[0], fe[0], ov[0], bz[0]}, 32'h0);
    reset_n = 1'b1;
    tick(4);

    // 8N1 0xA5 with data_ready=1: one-cycle valid, exact latency
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    tick(2);
    chk("a5_count", n_dv[0], 1);
    chk("a5_data", last_dv[0], 9'h0A5);
    chk("a5_valid_cycles", n_hi[0], 1);
    chk("a5_errors", n_pe[0] + n_fe[0] + n_ov[0], 0);
    chk("a5_latency", rise_cyc[0] - start_cyc[0] - 1, 2 + CPB * (1 + 8 + 0 + 1 - 1) + MID + 2);

    // 8E1 0x3C, parity bit 0 good then 1 bad
    send(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    tick(2);
    chk("e1_good_count", n_dv[1], 1);
    chk("e1_good_data", last_dv[1], 9'h03C);
    chk("e1_good_perr", n_pe[1], 0);
    send(1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    tick(2);
    chk("e1_bad_perr", n_pe[1], 1);
    chk("e1_bad_count", n_dv[1], 1);
    chk("e1_bad_valid", dv[1], 0);
    chk("e1_bad_ferr", n_fe[1], 0);

    // 7O2 0x55 with second stop low, then a 30-bit break, then 0x12
    send(2, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
    line[2] = 1'b0;
    tick(31 * CPB);
    chk("o2_ferr", n_fe[2], 1);
    chk("o2_break_count", n_dv[2], 0);
    chk("o2_break_perr", n_pe[2], 0);
    line[2] = 1'b1;
    tick(2 * CPB);
    send(2, {2'b11, 1'b1, 7'h12, 1'b0}, 11);
    tick(2);
    chk("o2_after_count", n_dv[2], 1);
    chk("o2_after_data", last_dv[2], 9'h012);
    chk("o2_after_ferr", n_fe[2], 1);

    // Idle-line glitches: 1 cycle, then CPB/4 cycles
    line[0] = 1'b0;
    tick(1);
    line[0] = 1'b1;
    tick(3 * CPB);
    chk("glitch1_count", n_dv[0], 1);
    chk("glitch1_errors", n_pe[0] + n_fe[0] + n_ov[0], 0);
    chk("glitch1_busy", bz[0], 0);
    line[0] = 1'b0;
    tick(CPB / 4);
    line[0] = 1'b1;
    tick(3 * CPB);
    chk("glitch4_count", n_dv[0], 1);
    chk("glitch4_errors", n_pe[0] + n_fe[0] + n_ov[0], 0);

    // One-cycle high spike at the centre of data bit 3 of 0xF0
    send(0, {1'b1, 8'hF0, 1'b0}, 10, 4, 9);
    tick(2);
    chk("spike_count", n_dv[0], 2);
    chk("spike_data", last_dv[0], 9'h0F0);

    // Back-to-back 0x11, 0x22 with data_ready low
    rdy[0] = 1'b0;
    send(0, {1'b1, 8'h11, 1'b0}, 10);
    send(0, {1'b1, 8'h22, 1'b0}, 10);
    tick(2);
    chk("ovr_pulse", n_ov[0], 1);
    chk("ovr_hold_data", {24'd0, d0}, 32'h11);
    chk("ovr_valid", dv[0], 1);
    chk("ovr_count", n_dv[0], 3);
    rdy[0] = 1'b1;
    tick(1);
    chk("ovr_consume_valid", dv[0], 0);
    chk("ovr_consume_word", last_acc[0], 9'h011);
    chk("ovr_consume_count", n_acc[0], 3);

    // Reset in the middle of data bit 4 of 0x81, then a clean 0x81
    fork
      send(0, {1'b1, 8'h81, 1'b0}, 10);
      begin
        tick(5 * CPB + 8);
        chk("midframe_busy", bz[0], 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_dout", {24'd0, d0}, 32'h0);
        chk("midreset_flags", {dv[0], pe[0], fe[0], ov[0], bz[0]}, 32'h0);
      end
    join
    reset_n = 1'b1;
    tick(4);
    chk("midreset_nodeliver", n_dv[0], 3);
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    tick(2);
    chk("post_reset_count", n_dv[0], 4);
    chk("post_reset_data", last_dv[0], 9'h081);
    chk("post_reset_errors", n_pe[0] + n_fe[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
